// File: rtl/mac_pkg.sv
// mac_pkg: shared definitions for the RGMII MAC transmit and receive paths.
//   - tx_state_e     : transmit framer state encoding
//   - ETH_* / CRC32_*: framing and CRC constants
//   - crc32_d8       : byte-wide CRC-32 next-state function (also used on receive)
//   - bit_reverse32  : helper used to turn the CRC register into the FCS
//   - crc32_residue_ok: receive-side check of the CRC register after FCS
package mac_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_SFD,
    ST_DATA,
    ST_PAD,
    ST_FCS,
    ST_IFG
  } tx_state_e;

  localparam logic [7:0]  ETH_PREAMBLE  = 8'h55;
  localparam logic [7:0]  ETH_SFD       = 8'hD5;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hC704DD7B;
  localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;

  // Register is kept MSB-first; each data byte is consumed LSB first,
  // matching Ethernet bit order on the wire.
  function automatic logic [31:0] crc32_d8(input logic [7:0] d, input logic [31:0] c);
    logic [31:0] r;
    logic [7:0]  dd;
    logic        fb;
    r  = c;
    dd = d;
    for (int unsigned i = 0; i < 8; i++) begin
      fb = r[31] ^ dd[0];
      r  = {r[30:0], 1'b0};
      if (fb) begin
        r = r ^ CRC32_POLY;
      end
      dd = dd >> 1;
    end
    return r;
  endfunction

  function automatic logic [31:0] bit_reverse32(input logic [31:0] v);
    logic [31:0] r;
    logic [31:0] t;
    r = '0;
    t = v;
    for (int unsigned i = 0; i < 32; i++) begin
      r = {r[30:0], t[0]};
      t = t >> 1;
    end
    return r;
  endfunction

  function automatic logic crc32_residue_ok(input logic [31:0] c);
    return c == CRC32_RESIDUE;
  endfunction

endpackage

// File: rtl/eth_crc32_d8.sv
// eth_crc32_d8: registered CRC-32 engine, one byte per clock.
//   clk_i  : byte clock
//   rst_i  : asynchronous active-high reset (register returns to CRC32_INIT)
//   init_i : load CRC32_INIT on the next edge (priority over en_i)
//   en_i   : fold data_i into the register on the next edge
//   data_i : byte to fold in
//   crc_o  : current register value
module eth_crc32_d8
  import mac_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        init_i,
  input  logic        en_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);

  logic [31:0] crc_q;
  logic [31:0] crc_d;

  always_comb begin
    crc_d = crc_q;
    if (init_i) begin
      crc_d = CRC32_INIT;
    end else if (en_i) begin
      crc_d = crc32_d8(data_i, crc_q);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      crc_q <= CRC32_INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/mac_tx_framer.sv
// mac_tx_framer: GMII transmit framer. Wraps a sof/eof/valid byte stream in
// preamble + SFD, pads the body to MIN_FRAME bytes, appends the FCS and
// enforces IFG_BYTES idle cycles between frames.
//   mac_tx_clk    : 125 MHz byte clock
//   rst           : asynchronous active-high reset
//   mac_tx_sof    : first byte of a frame (only looked at in IDLE)
//   mac_tx_eof    : last byte of a frame
//   mac_tx_valid  : byte valid
//   mac_tx_data   : frame byte, destination MAC first
//   mac_tx_rdy    : byte accepted when valid && rdy (pure state decode)
//   gmii_txd      : registered transmit byte
//   gmii_tx_en    : registered frame enable
//   gmii_tx_er    : registered error flag (set on the underrun byte)
//   tx_underrun_o : one-cycle pulse when a frame is aborted by underrun
module mac_tx_framer
  import mac_pkg::*;
#(
  parameter int unsigned PREAMBLE_LEN = 7,
  parameter int unsigned MIN_FRAME    = 60,
  parameter int unsigned IFG_BYTES    = 12
) (
  input  logic       mac_tx_clk,
  input  logic       rst,
  input  logic       mac_tx_sof,
  input  logic       mac_tx_eof,
  input  logic       mac_tx_valid,
  input  logic [7:0] mac_tx_data,
  output logic       mac_tx_rdy,
  output logic [7:0] gmii_txd,
  output logic       gmii_tx_en,
  output logic       gmii_tx_er,
  output logic       tx_underrun_o
);

  localparam logic [15:0] PRE_LAST = 16'(PREAMBLE_LEN - 1);
  localparam logic [15:0] IFG_LAST = 16'((IFG_BYTES > 0) ? IFG_BYTES - 1 : 0);
  localparam logic [10:0] MIN_CNT  = 11'(MIN_FRAME);

  tx_state_e   state_q, state_d;
  logic [15:0] cnt_q, cnt_d;     // preamble / FCS byte / IFG cycle counter
  logic [10:0] bcnt_q, bcnt_d;   // body byte count, saturating
  logic [7:0]  txd_q, txd_d;
  logic        en_q, en_d;
  logic        er_q, er_d;
  logic        urun_q, urun_d;

  logic        crc_init;
  logic        crc_en;
  logic [7:0]  crc_data;
  logic [31:0] crc;
  logic [31:0] fcs;
  logic [10:0] bcnt_inc;

  eth_crc32_d8 u_crc (
    .clk_i  (mac_tx_clk),
    .rst_i  (rst),
    .init_i (crc_init),
    .en_i   (crc_en),
    .data_i (crc_data),
    .crc_o  (crc)
  );

  assign fcs      = bit_reverse32(~crc);
  assign bcnt_inc = (bcnt_q == '1) ? bcnt_q : bcnt_q + 11'd1;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bcnt_d   = bcnt_q;
    txd_d    = 8'h00;
    en_d     = 1'b0;
    er_d     = 1'b0;
    urun_d   = 1'b0;
    crc_init = 1'b0;
    crc_en   = 1'b0;
    crc_data = mac_tx_data;
    case (state_q)
      ST_IDLE: begin
        // sof byte is left with the source; it is taken in DATA.
        if (mac_tx_valid && mac_tx_sof) begin
          txd_d   = ETH_PREAMBLE;
          en_d    = 1'b1;
          cnt_d   = 16'd1;
          state_d = (PREAMBLE_LEN > 1) ? ST_PRE : ST_SFD;
        end
      end
      ST_PRE: begin
        txd_d = ETH_PREAMBLE;
        en_d  = 1'b1;
        cnt_d = cnt_q + 16'd1;
        if (cnt_q >= PRE_LAST) begin
          state_d = ST_SFD;
        end
      end
      ST_SFD: begin
        txd_d    = ETH_SFD;
        en_d     = 1'b1;
        crc_init = 1'b1;
        bcnt_d   = '0;
        state_d  = ST_DATA;
      end
      ST_DATA: begin
        en_d  = 1'b1;
        cnt_d = '0;
        if (mac_tx_valid) begin
          txd_d  = mac_tx_data;
          crc_en = 1'b1;
          bcnt_d = bcnt_inc;
          if (mac_tx_eof) begin
            state_d = (bcnt_inc < MIN_CNT) ? ST_PAD : ST_FCS;
          end
        end else begin
          // Underrun: poison the frame with tx_er and drop the FCS.
          txd_d   = 8'h00;
          er_d    = 1'b1;
          urun_d  = 1'b1;
          state_d = ST_IFG;
        end
      end
      ST_PAD: begin
        txd_d    = 8'h00;
        en_d     = 1'b1;
        crc_en   = 1'b1;
        crc_data = 8'h00;
        bcnt_d   = bcnt_inc;
        cnt_d    = '0;
        if (bcnt_inc >= MIN_CNT) begin
          state_d = ST_FCS;
        end
      end
      ST_FCS: begin
        en_d  = 1'b1;
        cnt_d = cnt_q + 16'd1;
        case (cnt_q[1:0])
          2'd0:    txd_d = fcs[7:0];
          2'd1:    txd_d = fcs[15:8];
          2'd2:    txd_d = fcs[23:16];
          default: txd_d = fcs[31:24];
        endcase
        if (cnt_q[1:0] == 2'd3) begin
          cnt_d   = '0;
          state_d = ST_IFG;
        end
      end
      ST_IFG: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q >= IFG_LAST) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge mac_tx_clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bcnt_q  <= '0;
      txd_q   <= '0;
      en_q    <= 1'b0;
      er_q    <= 1'b0;
      urun_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bcnt_q  <= bcnt_d;
      txd_q   <= txd_d;
      en_q    <= en_d;
      er_q    <= er_d;
      urun_q  <= urun_d;
    end
  end

  assign mac_tx_rdy    = (state_q == ST_DATA);
  assign gmii_txd      = txd_q;
  assign gmii_tx_en    = en_q;
  assign gmii_tx_er    = er_q;
  assign tx_underrun_o = urun_q;

endmodule

// File: tb/tb_mac_tx_framer.sv
// tb_mac_tx_framer: randomized self-checking bench for mac_tx_framer.
// Expected wire frames are built from the frame rules (preamble, SFD, body
// padded to 60, little-endian reflected CRC-32) and compared byte by byte.
module tb_mac_tx_framer;

  localparam int PRE  = 7;
  localparam int MINF = 60;
  localparam int IFG  = 12;

  typedef logic [7:0] byte_q_t[$];

  logic       mac_tx_clk   = 1'b0;
  logic       rst          = 1'b1;
  logic       mac_tx_sof   = 1'b0;
  logic       mac_tx_eof   = 1'b0;
  logic       mac_tx_valid = 1'b0;
  logic [7:0] mac_tx_data  = 8'h00;
  logic       mac_tx_rdy;
  logic [7:0] gmii_txd;
  logic       gmii_tx_en;
  logic       gmii_tx_er;
  logic       tx_underrun_o;

  int checks = 0;
  int errors = 0;

  mac_tx_framer #(
    .PREAMBLE_LEN (PRE),
    .MIN_FRAME    (MINF),
    .IFG_BYTES    (IFG)
  ) dut (
    .mac_tx_clk    (mac_tx_clk),
    .rst           (rst),
    .mac_tx_sof    (mac_tx_sof),
    .mac_tx_eof    (mac_tx_eof),
    .mac_tx_valid  (mac_tx_valid),
    .mac_tx_data   (mac_tx_data),
    .mac_tx_rdy    (mac_tx_rdy),
    .gmii_txd      (gmii_txd),
    .gmii_tx_en    (gmii_tx_en),
    .gmii_tx_er    (gmii_tx_er),
    .tx_underrun_o (tx_underrun_o)
  );

  always #4 mac_tx_clk = ~mac_tx_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] crc_raw(input byte_q_t q);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (q[i]) begin
      c = c ^ {24'h0, q[i]};
      for (int b = 0; b < 8; b++) begin
        c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
    end
    return c;
  endfunction

  function automatic logic [31:0] rev32(input logic [31:0] v);
    logic [31:0] r;
    logic [31:0] t;
    r = '0;
    t = v;
    for (int i = 0; i < 32; i++) begin
      r = {r[30:0], t[0]};
      t = t >> 1;
    end
    return r;
  endfunction

  function automatic byte_q_t exp_frame(input byte_q_t d, input int cut);
    byte_q_t q;
    byte_q_t body;
    logic [31:0] fcs;
    logic [31:0] t;
    repeat (PRE) q.push_back(8'h55);
    q.push_back(8'hD5);
    if (cut > 0) begin
      for (int i = 0; i < cut; i++) q.push_back(d[i]);
      q.push_back(8'h00);
      return q;
    end
    body = d;
    while (body.size() < MINF) body.push_back(8'h00);
    fcs = ~crc_raw(body);
    foreach (body[i]) q.push_back(body[i]);
    for (int i = 0; i < 4; i++) begin
      t = fcs >> (8 * i);
      q.push_back(t[7:0]);
    end
    return q;
  endfunction

  function automatic byte_q_t rand_bytes(input int n);
    byte_q_t q;
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
    return q;
  endfunction

  // ---------------- wire monitor ----------------
  byte_q_t cur_q, done_q;
  bit in_fr = 0;
  bit have_prev = 0;
  int cur_er = 0, cur_er_idx = -1, rdy_lat = -1, low_cnt = 0, last_gap = -1;
  int done_er = 0, done_er_idx = -1, done_gap = -1, done_rdy = -1;
  int nframes = 0;
  int urun_cnt = 0;

  always @(negedge mac_tx_clk) begin
    if (rst) begin
      in_fr     = 0;
      have_prev = 0;
      low_cnt   = 0;
      cur_q.delete();
    end else begin
      if (gmii_tx_en) begin
        if (!in_fr) begin
          in_fr      = 1;
          cur_q.delete();
          cur_er     = 0;
          cur_er_idx = -1;
          rdy_lat    = -1;
          last_gap   = have_prev ? low_cnt : -1;
        end
        cur_q.push_back(gmii_txd);
        if (gmii_tx_er) begin
          cur_er++;
          cur_er_idx = cur_q.size() - 1;
        end
        if (mac_tx_rdy && rdy_lat < 0) rdy_lat = cur_q.size() - 1;
      end else begin
        if (in_fr) begin
          in_fr       = 0;
          done_q      = cur_q;
          done_er     = cur_er;
          done_er_idx = cur_er_idx;
          done_gap    = last_gap;
          done_rdy    = rdy_lat;
          have_prev   = 1;
          low_cnt     = 0;
          nframes++;
        end
        low_cnt++;
      end
      if (tx_underrun_o) urun_cnt++;
    end
  end

  // ---------------- driver ----------------
  // Returns once `cut` bytes are accepted (cut=0: whole frame). With drop set,
  // valid is released at the cut point to provoke an underrun.
  task automatic send_frame(input byte_q_t d, input int cut, input bit drop);
    int idx;
    int guard;
    bit acc;
    idx          = 0;
    guard        = 0;
    mac_tx_sof   = 1'b1;
    mac_tx_valid = 1'b1;
    mac_tx_data  = d[0];
    mac_tx_eof   = (d.size() == 1);
    while (idx < d.size()) begin
      @(negedge mac_tx_clk);
      acc = mac_tx_rdy;
      @(posedge mac_tx_clk);
      #1;
      if (acc) begin
        idx++;
        if (idx == cut) begin
          if (drop) begin
            mac_tx_valid = 1'b0;
            mac_tx_sof   = 1'b0;
            mac_tx_eof   = 1'b0;
          end
          return;
        end
        if (idx < d.size()) begin
          mac_tx_data = d[idx];
          mac_tx_sof  = 1'b0;
          mac_tx_eof  = (idx == d.size() - 1);
        end
      end
      guard++;
      if (guard > 3000) begin
        chk("drv_timeout", idx, d.size());
        break;
      end
    end
    mac_tx_valid = 1'b0;
    mac_tx_sof   = 1'b0;
    mac_tx_eof   = 1'b0;
  endtask

  task automatic wait_frames(input int n);
    int g;
    g = 0;
    while (nframes < n && g < 3000) begin
      @(negedge mac_tx_clk);
      g++;
    end
    chk("frame_wait", nframes, n);
  endtask

  task automatic check_frame(input string tag, input byte_q_t d, input int cut);
    byte_q_t e;
    byte_q_t body;
    int n;
    int e0;
    e = exp_frame(d, cut);
    chk({tag, "_len"}, done_q.size(), e.size());
    n = (done_q.size() < e.size()) ? done_q.size() : e.size();
    for (int i = 0; i < n; i++) begin
      e0 = errors;
      chk($sformatf("%s_byte%0d", tag, i), {24'h0, done_q[i]}, {24'h0, e[i]});
      if (errors != e0) break;
    end
    chk({tag, "_er_count"}, done_er, (cut > 0) ? 1 : 0);
    chk({tag, "_rdy_lat"}, done_rdy, PRE);
    if (cut > 0) begin
      chk({tag, "_er_pos"}, done_er_idx, PRE + 1 + cut);
    end else if (done_q.size() > PRE + 1) begin
      body = done_q[PRE+1:$];
      chk({tag, "_residue"}, rev32(crc_raw(body)), 32'hC704DD7B);
    end
  endtask

  // ---------------- stimulus ----------------
  byte_q_t fa, fb, fc;
  int lens[6];
  int u0;
  int nf;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge mac_tx_clk);
    chk("rst_txd", {24'h0, gmii_txd}, 32'h0);
    chk("rst_en", {31'h0, gmii_tx_en}, 32'h0);
    chk("rst_er", {31'h0, gmii_tx_er}, 32'h0);
    chk("rst_rdy", {31'h0, mac_tx_rdy}, 32'h0);
    chk("rst_urun", {31'h0, tx_underrun_o}, 32'h0);
    @(posedge mac_tx_clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge mac_tx_clk);
    #1;

    // Minimum ARP reply: 42 bytes, padded to 60
    fa = {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
          8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h08, 8'h06};
    fb = rand_bytes(28);
    foreach (fb[i]) fa.push_back(fb[i]);
    send_frame(fa, 0, 0);
    wait_frames(1);
    check_frame("arp", fa, 0);
    chk("arp_en_cycles", done_q.size(), 72);

    // 64-byte body, no padding
    fa = rand_bytes(64);
    send_frame(fa, 0, 0);
    wait_frames(2);
    check_frame("len64", fa, 0);
    chk("len64_en_cycles", done_q.size(), 76);

    // Back-to-back: second sof held while the first frame finishes
    fa = rand_bytes($urandom_range(1, 100));
    fb = rand_bytes($urandom_range(1, 100));
    fork
      begin
        send_frame(fa, 0, 0);
        send_frame(fb, 0, 0);
      end
    join_none
    wait_frames(3);
    check_frame("b2b_a", fa, 0);
    wait_frames(4);
    check_frame("b2b_b", fb, 0);
    chk("b2b_gap", done_gap, IFG);

    // Underrun after the 20th byte, next frame queued right behind it
    u0 = urun_cnt;
    fa = rand_bytes(40);
    fb = rand_bytes($urandom_range(10, 80));
    fork
      begin
        send_frame(fa, 20, 1);
        @(posedge mac_tx_clk);
        #1;
        send_frame(fb, 0, 0);
      end
    join_none
    wait_frames(5);
    check_frame("urun", fa, 20);
    chk("urun_pulse", urun_cnt - u0, 1);
    wait_frames(6);
    check_frame("post_urun", fb, 0);
    chk("urun_ifg", done_gap, IFG);

    // Single-byte frame
    fa = {8'h30};
    send_frame(fa, 0, 0);
    wait_frames(7);
    check_frame("single", fa, 0);
    chk("single_en_cycles", done_q.size(), 72);

    // Length boundaries around MIN_FRAME plus random lengths
    lens = '{59, 60, 61, $urandom_range(1, 150), $urandom_range(1, 150), $urandom_range(1, 150)};
    for (int k = 0; k < 6; k++) begin
      repeat ($urandom_range(0, 20)) @(posedge mac_tx_clk);
      #1;
      fa = rand_bytes(lens[k]);
      send_frame(fa, 0, 0);
      wait_frames(8 + k);
      check_frame($sformatf("len%0d", lens[k]), fa, 0);
    end

    // Reset mid-payload, then a clean frame
    fa = rand_bytes(50);
    nf = nframes;
    send_frame(fa, 10, 0);
    #1 rst = 1'b1;
    #1;
    chk("midrst_en", {31'h0, gmii_tx_en}, 32'h0);
    chk("midrst_er", {31'h0, gmii_tx_er}, 32'h0);
    chk("midrst_rdy", {31'h0, mac_tx_rdy}, 32'h0);
    chk("midrst_txd", {24'h0, gmii_txd}, 32'h0);
    mac_tx_valid = 1'b0;
    mac_tx_sof   = 1'b0;
    mac_tx_eof   = 1'b0;
    repeat (3) @(posedge mac_tx_clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge mac_tx_clk);
    #1;
    chk("midrst_no_frame", nframes, nf);
    fb = rand_bytes($urandom_range(20, 90));
    send_frame(fb, 0, 0);
    wait_frames(nf + 1);
    check_frame("post_rst", fb, 0);

    repeat (20) @(negedge mac_tx_clk);
    chk("urun_total", urun_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mac_tx_framer.md
# mac_tx_framer

Transmit-side Ethernet framer for the RGMII MAC: takes a byte stream (sof/eof/valid) from the UDP/ARP/GVCP/GVSP transmit logic and produces a complete GMII frame: preamble, SFD, payload, zero padding to the 60-byte minimum, FCS, and the inter-frame gap. It sits in the `mac_tx_clk` domain, in front of the RGMII DDR output stage that drives `phy_txd` and `phy_tx_ctrl`. It is the counterpart of the receive path that checks preamble and CRC on `phy_rxd`.

## Interface
- `PREAMBLE_LEN`, default 7: number of 0x55 bytes sent before the SFD.
- `MIN_FRAME`, default 60: minimum byte count of destination + source + type + payload + pad, excluding FCS.
- `IFG_BYTES`, default 12: idle cycles forced after each frame.

Ports:
- `mac_tx_clk` in 1: 125 MHz byte clock; the only clock.
- `rst` in 1: reset, asynchronous, active-high.
- `mac_tx_sof` in 1: first byte of a frame; sampled only in IDLE.
- `mac_tx_eof` in 1: last byte of a frame.
- `mac_tx_valid` in 1: byte valid.
- `mac_tx_data` in 8: frame byte, destination MAC first.
- `mac_tx_rdy` out 1: byte accepted on any edge where `mac_tx_valid && mac_tx_rdy`.
- `gmii_txd` out 8: registered transmit byte.
- `gmii_tx_en` out 1: registered frame enable.
- `gmii_tx_er` out 1: registered error flag.
- `tx_underrun_o` out 1: one-cycle pulse when a frame is aborted.

## Operation
- States, in order: IDLE, PRE, SFD, DATA, PAD, FCS, IFG.
- **IDLE**
  - `mac_tx_rdy` = 0.
  - On `mac_tx_valid && mac_tx_sof`: load `gmii_txd` = 0x55 and `gmii_tx_en` = 1, set `cnt` = 1, go to PRE.
  - The sof byte is not consumed here; the source holds it.
- **PRE**: load 0x55 each cycle. When `cnt == PREAMBLE_LEN-1`, go to SFD.
- **SFD**
  - Load 0xD5.
  - Initialise CRC to 0xFFFFFFFF and the byte counter to 0.
  - Go to DATA.
- **DATA**
  - `mac_tx_rdy` = 1.
  - On valid: load `mac_tx_data`, update the CRC, increment the byte counter.
  - On eof: go to PAD if the count after this byte is < `MIN_FRAME`, otherwise go to FCS.
  - `mac_tx_sof` is ignored in DATA.
- **Underrun** (`mac_tx_valid` = 0 in DATA):
  - Load `gmii_txd` = 0x00 with `gmii_tx_er` = 1 and `gmii_tx_en` = 1 for one cycle.
  - Pulse `tx_underrun_o`.
  - Skip FCS and go to IFG. Remaining source bytes are not drained; that is the source's responsibility.
- **PAD**: load 0x00 and update the CRC until the byte count reaches `MIN_FRAME`, then go to FCS.
- **FCS**
  - FCS = bit-reverse(~crc).
  - Send 4 bytes, `fcs[7:0]` first, then `[15:8]`, `[23:16]`, `[31:24]`.
  - After the 4th byte, go to IFG.
- **IFG**: `gmii_tx_en` = 0 and `gmii_txd` = 0x00 for `IFG_BYTES` cycles, then IDLE.
- **CRC**: IEEE 802.3 polynomial, reflected; 8-bit-per-cycle update identical to the receive-side NextCRC(D, C).
- **Byte counter**: 11 bits, saturating at 2047. There is no truncation of long frames.

## Timing
- Reset values: `gmii_txd` = 0x00, `gmii_tx_en` = 0, `gmii_tx_er` = 0, `mac_tx_rdy` = 0, `tx_underrun_o` = 0, state IDLE.
- Reset takes effect immediately, including mid-frame; `gmii_tx_en` falls asynchronously. Any partial frame is truncated.
- Latency from sof sampled at edge k:
  - Preamble bytes load at edges k .. k+PREAMBLE_LEN-1.
  - SFD loads at k+PREAMBLE_LEN.
  - `mac_tx_rdy` is high from k+PREAMBLE_LEN+1 onward.
  - Each accepted byte appears on `gmii_txd` one edge after acceptance.
- `gmii_tx_en` stays continuously high from the first preamble byte through the last FCS byte.
- `mac_tx_rdy` is a decode of the registered state only; no combinational path from inputs.
- A sof presented during IFG or earlier states waits. Minimum gap between frames is exactly `IFG_BYTES` cycles of `gmii_tx_en` = 0.
- Single-byte frame (sof and eof on the same byte) is legal: 1 byte, 59 pad bytes, FCS.

## Structure
- Shared package `mac_pkg` holds:
  - the state enum;
  - constants `ETH_PREAMBLE` = 8'h55, `ETH_SFD` = 8'hD5, `CRC32_INIT` = 32'hFFFFFFFF, `CRC32_RESIDUE` = 32'hC704DD7B;
  - the `crc32_d8` next-state function, shared with the receive path.
- One sub-module `eth_crc32_d8`: registered CRC engine with init, enable and data inputs, and a 32-bit state output.

## Test plan
- **Minimum ARP reply**: 42-byte frame (dst FFFF_FFFF_FFFF, src 0102_0304_0506, type 0806) → 7×0x55, D5, 42 data bytes, 18×0x00, 4 FCS.
  - `gmii_tx_en` is high for exactly 72 cycles.
  - CRC over data + pad + FCS equals 0xC704DD7B.
- **64-byte payload frame** → no padding; `gmii_tx_en` is high for 76 cycles; FCS equals the reference model, LSB byte first.
- **Back-to-back frames**: second sof held during the first frame → `gmii_tx_en` is low for exactly 12 cycles between frames; the second preamble starts on the 13th cycle.
- **Underrun**: drop `mac_tx_valid` after the 20th byte → one cycle with `gmii_tx_er` = 1 and `gmii_txd` = 0x00, `tx_underrun_o` pulses once, no FCS is sent, IFG of 12 cycles follows.
- **Single-byte frame** (sof = eof, 0x30) → 60-byte body (0x30 plus 59×0x00) and a valid FCS.
- **Reset asserted mid-payload** → `gmii_tx_en`, `gmii_tx_er` and `mac_tx_rdy` go to 0 immediately. After release, the next sof produces a clean frame with a valid FCS.
